// File: rtl/dnn2ami_wr_sequencer_if.sv
// Bus bundle between the DNN write sequencer, the PU output buffers and the AMI write port.
// perf_beats/perf_stall exist only when DNN2AMI_WRSEQ_PERF_EN is defined.
interface dnn2ami_wr_sequencer_if #(
  parameter int NUM_PU = 2,
  parameter int DATA_W = 512,
  parameter int ADDR_W = 64
);
  logic                     wr_req;
  logic [ADDR_W-1:0]        wr_addr;
  logic [9:0]               wr_req_size;
  logic                     wr_req_ready;
  logic [NUM_PU-1:0]        outbuf_empty;
  logic [NUM_PU*DATA_W-1:0] outbuf_data;
  logic [NUM_PU-1:0]        outbuf_pop;
  logic                     mem_req_valid;
  logic                     mem_req_ready;
  logic [ADDR_W-1:0]        mem_req_addr;
  logic [DATA_W-1:0]        mem_req_data;
  logic                     busy;
`ifdef DNN2AMI_WRSEQ_PERF_EN
  logic [31:0]              perf_beats;
  logic [31:0]              perf_stall;

  modport slave (
    input  wr_req, wr_addr, wr_req_size, outbuf_empty, outbuf_data, mem_req_ready,
    output wr_req_ready, outbuf_pop, mem_req_valid, mem_req_addr, mem_req_data, busy,
           perf_beats, perf_stall
  );
  modport master (
    output wr_req, wr_addr, wr_req_size, outbuf_empty, outbuf_data, mem_req_ready,
    input  wr_req_ready, outbuf_pop, mem_req_valid, mem_req_addr, mem_req_data, busy,
           perf_beats, perf_stall
  );
`else
  modport slave (
    input  wr_req, wr_addr, wr_req_size, outbuf_empty, outbuf_data, mem_req_ready,
    output wr_req_ready, outbuf_pop, mem_req_valid, mem_req_addr, mem_req_data, busy
  );
  modport master (
    output wr_req, wr_addr, wr_req_size, outbuf_empty, outbuf_data, mem_req_ready,
    input  wr_req_ready, outbuf_pop, mem_req_valid, mem_req_addr, mem_req_data, busy
  );
`endif
endinterface

// File: rtl/dnn2ami_wr_sequencer.sv
// Write sequencer: queues macro write requests and fractures them into AMI beats, one
// output-buffer word per beat in strict PU round-robin. Optional DNN2AMI_WRSEQ_PERF_EN counters.
module dnn2ami_wr_sequencer #(
  parameter int NUM_PU        = 2,
  parameter int DATA_W        = 512,
  parameter int ADDR_W        = 64,
  parameter int BYTES_PER_REQ = 64,
  parameter int LOG_DEPTH     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  dnn2ami_wr_sequencer_if.slave bus
);
  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam int PU_W  = (NUM_PU > 1) ? $clog2(NUM_PU) : 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [9:0]        size;
  } mreq_t;

  typedef enum logic {IDLE, ISSUE} state_t;

  mreq_t                q_mem [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr, rd_ptr;
  logic [LOG_DEPTH:0]   q_cnt;
  mreq_t                head;

  state_t               state;
  logic [ADDR_W-1:0]    cur_addr;
  logic [9:0]           left;
  logic [PU_W-1:0]      pu_sel;

  logic                 enq, deq, hs;
  logic [NUM_PU-1:0]    pu_hit;
  logic [DATA_W-1:0]    pu_word [NUM_PU];

  assign bus.wr_req_ready = (q_cnt != (LOG_DEPTH+1)'(DEPTH));
  assign enq  = bus.wr_req && bus.wr_req_ready;
  assign deq  = (state == IDLE) && (q_cnt != '0);
  assign head = q_mem[rd_ptr];

  // Per-PU word select and pop decode; pop is only ever raised on the handshake cycle.
  for (genvar gi = 0; gi < NUM_PU; gi++) begin : g_pu
    assign pu_word[gi]        = bus.outbuf_data[gi*DATA_W +: DATA_W];
    assign pu_hit[gi]         = (pu_sel == PU_W'(gi));
    assign bus.outbuf_pop[gi] = hs && pu_hit[gi];
  end

  assign bus.mem_req_valid = (state == ISSUE) && |(pu_hit & ~bus.outbuf_empty);
  assign bus.mem_req_addr  = cur_addr;
  assign bus.mem_req_data  = pu_word[pu_sel];
  assign hs                = bus.mem_req_valid && bus.mem_req_ready;
  assign bus.busy          = (q_cnt != '0) || (state == ISSUE);

  always_ff @(posedge clk) begin
    if (enq) q_mem[wr_ptr] <= '{addr: bus.wr_addr, size: bus.wr_req_size};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      q_cnt    <= '0;
      state    <= IDLE;
      cur_addr <= '0;
      left     <= '0;
      pu_sel   <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + LOG_DEPTH'(1);
      if (deq) rd_ptr <= rd_ptr + LOG_DEPTH'(1);
      case ({enq, deq})
        2'b10:   q_cnt <= q_cnt + (LOG_DEPTH+1)'(1);
        2'b01:   q_cnt <= q_cnt - (LOG_DEPTH+1)'(1);
        default: q_cnt <= q_cnt;
      endcase

      case (state)
        IDLE: begin
          if (deq) begin
            cur_addr <= head.addr;
            left     <= head.size;
            pu_sel   <= '0;
            // zero-length requests retire here without touching the AMI port
            if (head.size != 10'd0) state <= ISSUE;
          end
        end
        ISSUE: begin
          if (hs) begin
            cur_addr <= cur_addr + ADDR_W'(BYTES_PER_REQ);
            left     <= left - 10'd1;
            pu_sel   <= (pu_sel == PU_W'(NUM_PU-1)) ? '0 : pu_sel + PU_W'(1);
            if (left == 10'd1) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DNN2AMI_WRSEQ_PERF_EN
  logic [31:0] beats_q, stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beats_q <= '0;
      stall_q <= '0;
    end else begin
      if (hs && (beats_q != '1)) beats_q <= beats_q + 32'd1;
      if (bus.mem_req_valid && !bus.mem_req_ready && (stall_q != '1)) stall_q <= stall_q + 32'd1;
    end
  end

  assign bus.perf_beats = beats_q;
  assign bus.perf_stall = stall_q;
`endif

endmodule
